nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder built on a single Hw_4bitFullAdder slice.

---
 rtl/nibble_serial_adder_pkg.sv | 22 ++
 rtl/Hw_4bitFullAdder.sv | 32 +++
 rtl/nibble_serial_adder.sv | 174 +++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
//   Shared definitions for the nibble-serial adder and its 4-bit slice:
//   nibble width, FSM state encoding and a helper that sizes the nibble
//   index register.
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index register width: enough bits to count 0..nibbles-1, never less than 1.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/Hw_4bitFullAdder.sv
// -----------------------------------------------------------------------------
// Hw_4bitFullAdder
//   Purely combinational 4-bit ripple-carry adder slice.
//   Ports (positional order is part of the interface):
//     sum   out [3:0]  a + b + cin, low 4 bits
//     c_out out        carry out of bit 3
//     a     in  [3:0]  addend
//     b     in  [3:0]  addend
//     cin   in         carry in
// -----------------------------------------------------------------------------
module Hw_4bitFullAdder
  import nibble_serial_adder_pkg::*;
(
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
    assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = w_carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder that reuses one 4-bit adder slice, processing
//   one nibble per clock from LSB to MSB with the carry held in a register.
//   Ports:
//     clk        in          clock, rising edge
//     rst        in          synchronous active-high reset
//     in_valid   in          operand pair presented
//     in_ready   out         operands accepted (IDLE only)
//     op_a, op_b in  [W-1:0] addends, captured on accept
//     cin        in          carry-in, captured on accept
//     out_valid  out         result available (DONE only)
//     out_ready  in          consumer takes result
//     sum        out [W-1:0] op_a + op_b + cin, modulo 2^WIDTH
//     c_out      out         carry out of bit WIDTH-1
//     busy       out         high in RUN or DONE
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH <= 0) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [NIBBLE_W-1:0] r_sum_nib [NIBBLES];

  // FSM decode
  logic w_accept;
  logic w_run;
  logic w_last;

  // Nibble mux / slice connections
  logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] w_slice_a;
  logic [NIBBLE_W-1:0] w_slice_b;
  logic [NIBBLE_W-1:0] w_slice_sum;
  logic                w_slice_cout;
  logic [NIBBLES-1:0]  w_nib_we;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        w_run = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latch, carry chain register and nibble index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= op_a;
      r_b     <= op_b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (w_run) begin
      r_carry <= w_slice_cout;
      if (w_last) begin
        // Wrap the index rather than letting it run past the last nibble.
        r_cout <= w_slice_cout;
        r_idx  <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Nibble mux on the latched operands, write-enable demux into the sum
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign w_a_nib[gi]  = r_a[gi*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib[gi]  = r_b[gi*NIBBLE_W +: NIBBLE_W];
    assign w_nib_we[gi] = w_run && (r_idx == IDX_W'(gi));

    // Each nibble only changes on its own RUN cycle, so the previous result
    // stays visible in IDLE and the new one fills in LSB first.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum_nib[gi] <= '0;
      end else if (w_nib_we[gi]) begin
        r_sum_nib[gi] <= w_slice_sum;
      end
    end

    assign sum[gi*NIBBLE_W +: NIBBLE_W] = r_sum_nib[gi];
  end

  assign w_slice_a = w_a_nib[r_idx];
  assign w_slice_b = w_b_nib[r_idx];

  Hw_4bitFullAdder u_slice (w_slice_sum, w_slice_cout, w_slice_a, w_slice_b, r_carry);

  assign c_out = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
//   Checks a 16-bit and an 8-bit instance: a table of directed adds, hand
//   sequences for backpressure, ignored in_valid during RUN and reset mid-RUN,
//   then randomized traffic against a plain-arithmetic reference queue.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int N_RAND     = 2000;
  localparam int RAND_LIMIT = 30000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Index 0 drives the WIDTH=16 instance, index 1 the WIDTH=8 instance.
  logic        in_valid  [2];
  logic [15:0] op_a      [2];
  logic [15:0] op_b      [2];
  logic        cin       [2];
  logic        out_ready [2];

  logic        in_ready_o  [2];
  logic        out_valid_o [2];
  logic        busy_o      [2];
  logic        c_out_o     [2];
  logic [15:0] sum_o       [2];

  logic        w16_in_ready, w16_out_valid, w16_busy, w16_c_out;
  logic [15:0] w16_sum;
  logic        w8_in_ready, w8_out_valid, w8_busy, w8_c_out;
  logic [7:0]  w8_sum;

  nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[0]),
    .in_ready  (w16_in_ready),
    .op_a      (op_a[0]),
    .op_b      (op_b[0]),
    .cin       (cin[0]),
    .out_valid (w16_out_valid),
    .out_ready (out_ready[0]),
    .sum       (w16_sum),
    .c_out     (w16_c_out),
    .busy      (w16_busy)
  );

  nibble_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid[1]),
    .in_ready  (w8_in_ready),
    .op_a      (op_a[1][7:0]),
    .op_b      (op_b[1][7:0]),
    .cin       (cin[1]),
    .out_valid (w8_out_valid),
    .out_ready (out_ready[1]),
    .sum       (w8_sum),
    .c_out     (w8_c_out),
    .busy      (w8_busy)
  );

  assign in_ready_o[0]  = w16_in_ready;
  assign out_valid_o[0] = w16_out_valid;
  assign busy_o[0]      = w16_busy;
  assign c_out_o[0]     = w16_c_out;
  assign sum_o[0]       = w16_sum;
  assign in_ready_o[1]  = w8_in_ready;
  assign out_valid_o[1] = w8_out_valid;
  assign busy_o[1]      = w8_busy;
  assign c_out_o[1]     = w8_c_out;
  assign sum_o[1]       = {8'h00, w8_sum};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        c;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation on the 16-bit instance. Operand inputs are scrambled right
  // after accept; optional in_valid pulse during RUN; optional hold in DONE.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input bit pulse, input int hold,
                       output logic [15:0] s, output logic c, output int lat);
    lat = -1;
    @(negedge clk);
    check("ready_before_op", 32'(in_ready_o[0]), 32'd1);
    in_valid[0]  = 1'b1;
    op_a[0]      = a;
    op_b[0]      = b;
    cin[0]       = ci;
    out_ready[0] = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        in_valid[0] = 1'b0;
        op_a[0]     = ~a;
        op_b[0]     = ~b;
        cin[0]      = ~ci;
      end
      if (pulse && cyc == 2) begin
        in_valid[0] = 1'b1;
        op_a[0]     = 16'hAAAA;
      end
      if (pulse && cyc == 3) in_valid[0] = 1'b0;
      if (out_valid_o[0]) begin
        lat = cyc - 1;
        break;
      end
    end
    in_valid[0] = 1'b0;
    s = sum_o[0];
    c = c_out_o[0];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_flags", {29'd0, out_valid_o[0], in_ready_o[0], busy_o[0]}, 32'b101);
      check("hold_result", {15'd0, c_out_o[0], sum_o[0]}, {15'd0, c, s});
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check("release_to_idle", {29'd0, in_ready_o[0], out_valid_o[0], busy_o[0]}, 32'b100);
    $display("[TB] w=16 op a=%h b=%h cin=%0d -> sum=%h c_out=%0d latency=%0d",
             a, b, ci, s, c, lat);
  endtask

  // Random traffic on instance u of width w, checked against a queue of
  // expected results computed with integer arithmetic.
  task automatic run_random(input int u, input int w);
    logic [16:0] exp_q [$];
    logic [16:0] held_val;
    logic [16:0] got;
    logic [16:0] exp;
    logic [15:0] mask;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    bit          held;
    int          issued;
    int          done_cnt;
    int          cyc;
    int          r;
    mask     = (w == 16) ? 16'hFFFF : 16'h00FF;
    held     = 1'b0;
    held_val = '0;
    issued   = 0;
    done_cnt = 0;
    cyc      = 0;
    while (done_cnt < N_RAND && cyc < RAND_LIMIT) begin
      @(negedge clk);
      cyc++;
      got = {c_out_o[u], sum_o[u]};
      if (held) begin
        check($sformatf("rand_w%0d_stable", w), {14'd0, out_valid_o[u], got},
              {14'd0, 1'b1, held_val});
      end
      a            = 16'($urandom) & mask;
      b            = 16'($urandom) & mask;
      ci           = 1'($urandom);
      in_valid[u]  = (issued < N_RAND) && ($urandom_range(0, 3) != 0);
      op_a[u]      = a;
      op_b[u]      = b;
      cin[u]       = ci;
      out_ready[u] = ($urandom_range(0, 3) != 0);
      if (in_valid[u] && in_ready_o[u]) begin
        r = int'(a) + int'(b) + int'(ci);
        exp_q.push_back({1'((r >> w) & 1), 16'(r) & mask});
        issued++;
      end
      if (out_valid_o[u]) begin
        if (out_ready[u]) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rand_w%0d_extra: got result 0x%0h, required no result", w, got);
          end else begin
            exp = exp_q.pop_front();
            check($sformatf("rand_w%0d_result", w), {15'd0, got}, {15'd0, exp});
            done_cnt++;
            $display("[TB] w=%0d rand #%0d result={c,sum}=%h ref=%h", w, done_cnt, got, exp);
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_val = got;
        end
      end else begin
        held = 1'b0;
      end
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    check($sformatf("rand_w%0d_count", w), done_cnt, N_RAND);
    check($sformatf("rand_w%0d_pending", w), exp_q.size(), 0);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    logic        c;
    int          lat;

    vecs[0] = '{a: 16'hFFFF, b: 16'h0001, ci: 1'b0, s: 16'h0000, c: 1'b1};
    vecs[1] = '{a: 16'h1234, b: 16'h4321, ci: 1'b1, s: 16'h5556, c: 1'b0};
    vecs[2] = '{a: 16'h8000, b: 16'h8000, ci: 1'b0, s: 16'h0000, c: 1'b1};
    vecs[3] = '{a: 16'hFFFF, b: 16'h0000, ci: 1'b1, s: 16'h0000, c: 1'b1};
    vecs[4] = '{a: 16'h0000, b: 16'h0000, ci: 1'b0, s: 16'h0000, c: 1'b0};
    vecs[5] = '{a: 16'hAAAA, b: 16'h5555, ci: 1'b1, s: 16'h0000, c: 1'b1};
    vecs[6] = '{a: 16'h7FFF, b: 16'h0001, ci: 1'b0, s: 16'h8000, c: 1'b0};
    vecs[7] = '{a: 16'h1111, b: 16'h2222, ci: 1'b0, s: 16'h3333, c: 1'b0};

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      op_a[u]      = '0;
      op_b[u]      = '0;
      cin[u]       = 1'b0;
      out_ready[u] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_flags_u%0d", u),
            {28'd0, in_ready_o[u], out_valid_o[u], busy_o[u], c_out_o[u]}, 32'b1000);
      check($sformatf("reset_sum_u%0d", u), {16'd0, sum_o[u]}, 32'd0);
    end

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, 0, s, c, lat);
      check($sformatf("vec%0d_sum", i), {16'd0, s}, {16'd0, vecs[i].s});
      check($sformatf("vec%0d_cout", i), {31'd0, c}, {31'd0, vecs[i].c});
      check($sformatf("vec%0d_latency", i), lat, 4);
    end

    // Backpressure: 6 cycles in DONE without out_ready
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 6, s, c, lat);
    check("bp_sum", {16'd0, s}, 32'h5556);
    check("bp_cout", {31'd0, c}, 32'd0);

    // in_valid pulse with other operands during RUN is ignored
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b1, 0, s, c, lat);
    check("ignore_sum", {16'd0, s}, 32'h1000);
    check("ignore_cout", {31'd0, c}, 32'd0);
    check("ignore_latency", lat, 4);

    // Reset at RUN idx=2: low two nibbles of the new op are already written
    @(negedge clk);
    in_valid[0] = 1'b1;
    op_a[0]     = 16'h1111;
    op_b[0]     = 16'h2222;
    cin[0]      = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("run_busy", {31'd0, busy_o[0]}, 32'd1);
    check("run_partial_sum", {16'd0, sum_o[0]}, 32'h1033);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_abort_flags",
          {28'd0, in_ready_o[0], out_valid_o[0], busy_o[0], c_out_o[0]}, 32'b1000);
    check("rst_abort_sum", {16'd0, sum_o[0]}, 32'd0);
    $display("[TB] w=16 op a=1111 b=2222 aborted by reset at idx=2");
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 0, s, c, lat);
    check("after_rst_sum", {16'd0, s}, 32'h3333);
    check("after_rst_cout", {31'd0, c}, 32'd0);

    // Randomized traffic on both widths
    run_random(0, 16);
    run_random(1, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
